// File: rtl/test_sdram_read.sv
// ---------------------------------------------------------------------------
// test_sdram_read
//
// Read-back checker for the SDRAM test pattern. After the pattern writer has
// filled word addresses 0..N_WORDS-1, this block issues pipelined reads on
// the controller's Avalon-style read port, compares every returned word with
// the expected pattern and reports pass/fail, an error count and the first
// mismatching address/data.
//
// Parameters:
//   N_WORDS      number of 16-bit words to check (1..511)
//   MAX_PENDING  maximum accepted reads awaiting data (1..15)
//
// Ports:
//   iCLK             clock, rising edge
//   iRST_N           asynchronous active-low reset
//   iSTART           level start, sampled in IDLE; also holds DONE
//   iWAIT_REQUEST    controller stall; request accepted when oRD_EN & ~stall
//   iRD_DATA         returned read data
//   iRD_DATAVALID    one returned word per high cycle, in request order
//   oRD_EN           read request
//   oRD_ADDR         word address (bits [24:9] always 0)
//   oDONE            check complete
//   oPASS            high in DONE when no mismatch was seen
//   oERR_CNT         number of mismatching words, saturating
//   oFIRST_ERR_ADDR  address of the first mismatch
//   oFIRST_ERR_DATA  data received at the first mismatch
//
// Build option:
//   TEST_SDRAM_READ_CAPTURE_EN  when defined, the first-error address/data
//   registers are built; otherwise those outputs are tied to 0.
// ---------------------------------------------------------------------------
module test_sdram_read #(
    parameter logic [8:0] N_WORDS     = 9'd400,
    parameter logic [3:0] MAX_PENDING = 4'd8
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic        iWAIT_REQUEST,
    input  logic [15:0] iRD_DATA,
    input  logic        iRD_DATAVALID,
    output logic        oRD_EN,
    output logic [24:0] oRD_ADDR,
    output logic        oDONE,
    output logic        oPASS,
    output logic [15:0] oERR_CNT,
    output logic [8:0]  oFIRST_ERR_ADDR,
    output logic [15:0] oFIRST_ERR_DATA
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [8:0]  issue_cnt;
    logic [8:0]  ret_cnt;
    logic [3:0]  pending;
    logic        rd_en;
    logic [15:0] err_cnt;
    logic        done;
    logic        pass;

    logic        accept;
    logic        ret;
    logic [7:0]  exp_base;
    logic [15:0] exp_word;
    logic        mismatch;
    logic [15:0] err_next;
    logic [3:0]  pending_next;
    logic        last_issue;
    logic        last_ret;

    // Returned data only counts while a check is running, so stale words
    // that arrive after a reset (in IDLE) or after completion are dropped.
    assign accept       = rd_en & ~iWAIT_REQUEST;
    assign ret          = iRD_DATAVALID & ((state == S_READ) | (state == S_DRAIN));
    assign exp_base     = {ret_cnt[6:3], ~ret_cnt[2], ret_cnt[1:0], 1'b0};
    assign exp_word     = {exp_base, exp_base | 8'h01};
    assign mismatch     = ret & (iRD_DATA != exp_word);
    assign err_next     = (mismatch && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
    assign pending_next = pending + {3'd0, accept} - {3'd0, ret};
    assign last_issue   = accept & (issue_cnt == (N_WORDS - 9'd1));
    assign last_ret     = ret & (ret_cnt == (N_WORDS - 9'd1));

    // Main controller. oRD_EN is a register computed from next-cycle pending,
    // so it always equals (pending < MAX_PENDING) during READ. A stalled
    // request cannot raise pending, which keeps oRD_EN and the address
    // stable for as long as the stall lasts.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= S_IDLE;
            issue_cnt <= 9'd0;
            ret_cnt   <= 9'd0;
            pending   <= 4'd0;
            rd_en     <= 1'b0;
            err_cnt   <= 16'd0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    issue_cnt <= 9'd0;
                    ret_cnt   <= 9'd0;
                    pending   <= 4'd0;
                    err_cnt   <= 16'd0;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    rd_en     <= 1'b0;
                    if (iSTART) begin
                        state <= S_READ;
                        rd_en <= 1'b1;
                    end
                end
                S_READ: begin
                    issue_cnt <= issue_cnt + {8'd0, accept};
                    ret_cnt   <= ret_cnt + {8'd0, ret};
                    pending   <= pending_next;
                    err_cnt   <= err_next;
                    if (last_issue) begin
                        state <= S_DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        rd_en <= (pending_next < MAX_PENDING);
                    end
                end
                S_DRAIN: begin
                    ret_cnt <= ret_cnt + {8'd0, ret};
                    pending <= pending_next;
                    err_cnt <= err_next;
                    rd_en   <= 1'b0;
                    if (last_ret) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (err_next == 16'd0);
                    end
                end
                default: begin
                    rd_en <= 1'b0;
                    if (!iSTART) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign oRD_EN   = rd_en;
    assign oRD_ADDR = {16'd0, issue_cnt};
    assign oDONE    = done;
    assign oPASS    = pass;
    assign oERR_CNT = err_cnt;

`ifdef TEST_SDRAM_READ_CAPTURE_EN
    logic [8:0]  first_addr;
    logic [15:0] first_data;

    // Only the very first mismatch of a run is latched; a zero error count
    // means nothing has been captured yet.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            first_addr <= 9'd0;
            first_data <= 16'd0;
        end else if (state == S_IDLE) begin
            first_addr <= 9'd0;
            first_data <= 16'd0;
        end else if (mismatch && (err_cnt == 16'd0)) begin
            first_addr <= ret_cnt;
            first_data <= iRD_DATA;
        end
    end

    assign oFIRST_ERR_ADDR = first_addr;
    assign oFIRST_ERR_DATA = first_data;
`else
    assign oFIRST_ERR_ADDR = 9'd0;
    assign oFIRST_ERR_DATA = 16'd0;
`endif

endmodule

// File: tb/tb_test_sdram_read.sv
// ---------------------------------------------------------------------------
// tb_test_sdram_read
//
// Bench for test_sdram_read. Two instances share all inputs: one checking
// 400 words and one checking a single word. A model SDRAM controller with
// configurable latency and random stalls answers the selected instance.
// Requested addresses are checked against a queue of expected addresses,
// and a model of the error counter / first-error registers is updated as
// each word is returned.
// ---------------------------------------------------------------------------
module tb_test_sdram_read;

    localparam int MAX_P = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        wait_req;
    logic [15:0] rd_data;
    logic        rd_valid;

    logic        a_rd_en, b_rd_en;
    logic [24:0] a_rd_addr, b_rd_addr;
    logic        a_done, b_done;
    logic        a_pass, b_pass;
    logic [15:0] a_err, b_err;
    logic [8:0]  a_fa, b_fa;
    logic [15:0] a_fd, b_fd;

    test_sdram_read #(.N_WORDS(9'd400), .MAX_PENDING(4'd8)) dut_main (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iWAIT_REQUEST(wait_req),
        .iRD_DATA(rd_data), .iRD_DATAVALID(rd_valid),
        .oRD_EN(a_rd_en), .oRD_ADDR(a_rd_addr), .oDONE(a_done), .oPASS(a_pass),
        .oERR_CNT(a_err), .oFIRST_ERR_ADDR(a_fa), .oFIRST_ERR_DATA(a_fd)
    );

    test_sdram_read #(.N_WORDS(9'd1), .MAX_PENDING(4'd8)) dut_one (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iWAIT_REQUEST(wait_req),
        .iRD_DATA(rd_data), .iRD_DATAVALID(rd_valid),
        .oRD_EN(b_rd_en), .oRD_ADDR(b_rd_addr), .oDONE(b_done), .oPASS(b_pass),
        .oERR_CNT(b_err), .oFIRST_ERR_ADDR(b_fa), .oFIRST_ERR_DATA(b_fd)
    );

    // Selected-instance view used by the controller model.
    logic        sel;
    logic        s_en, s_done, s_pass;
    logic [24:0] s_addr;
    logic [15:0] s_err, s_fd;
    logic [8:0]  s_fa;
    assign s_en   = sel ? b_rd_en   : a_rd_en;
    assign s_addr = sel ? b_rd_addr : a_rd_addr;
    assign s_done = sel ? b_done    : a_done;
    assign s_pass = sel ? b_pass    : a_pass;
    assign s_err  = sel ? b_err     : a_err;
    assign s_fa   = sel ? b_fa      : a_fa;
    assign s_fd   = sel ? b_fd      : a_fd;

    typedef struct {
        logic [8:0] addr;
        int         due;
    } flight_t;

    flight_t     inflight[$];
    int          exp_addr[$];
    int          tests_run;
    int          tests_failed;
    int          cyc;
    int          returned;
    bit          corrupt;
    logic [15:0] m_err;
    logic [8:0]  m_first_addr;
    logic [15:0] m_first_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] pattern(input logic [8:0] a);
        return {a[6:3], ~a[2], a[1:0], 1'b0, a[6:3], ~a[2], a[1:0], 1'b1};
    endfunction

    function automatic logic [15:0] mem_word(input logic [8:0] a);
        if (corrupt && a == 9'd17)  return 16'h0000;
        if (corrupt && a == 9'd300) return 16'hFFFF;
        return pattern(a);
    endfunction

    // Drive the return port for the upcoming edge; when counting, update the
    // expected error state the same way the checker should.
    task automatic deliver(input bit counting);
        flight_t     f;
        logic [8:0]  idx;
        logic [15:0] d;
        if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            f = inflight.pop_front();
            d = mem_word(f.addr);
            rd_valid = 1'b1;
            rd_data  = d;
            if (counting) begin
                idx = returned[8:0];
                if (d != pattern(idx)) begin
                    if (m_err == 16'd0) begin
                        m_first_addr = idx;
                        m_first_data = d;
                    end
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                end
                returned++;
            end
        end else begin
            rd_valid = 1'b0;
            rd_data  = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        start    = 1'b0;
        wait_req = 1'b0;
        rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one check on the selected instance. Ends at a negedge.
    task automatic run_check(input int lat, input int stall_pct, input int n,
                             input int abort_at, output bit aborted);
        bit          prev_stall;
        bit          first;
        bit          fin;
        logic [24:0] prev_addr;
        logic [15:0] exp_fd;
        logic [8:0]  exp_fa;
        int          a;
        int          guard;
        prev_stall = 1'b0;
        prev_addr  = '0;
        first      = 1'b1;
        fin        = 1'b0;
        aborted    = 1'b0;
        exp_addr.delete();
        for (int i = 0; i < n; i++) exp_addr.push_back(i);
        inflight.delete();
        returned     = 0;
        m_err        = 16'd0;
        m_first_addr = 9'd0;
        m_first_data = 16'd0;
        @(negedge clk);
        start    = 1'b1;
        wait_req = 1'b0;
        rd_valid = 1'b0;
        cyc      = 0;
        guard    = 0;
        while (guard < 20000) begin
            guard++;
            @(negedge clk);
            cyc++;
            tests_run++;
            if (s_err !== m_err) begin
                tests_failed++;
                $display("[TB] FAIL err_track: got %0d expected %0d at word %0d", s_err, m_err, returned);
            end
            tests_run++;
            if (s_done !== (returned == n)) begin
                tests_failed++;
                $display("[TB] FAIL done_timing: got %b expected %b at word %0d", s_done, (returned == n), returned);
            end
            if (s_done === 1'b1) begin
                fin = 1'b1;
                break;
            end
            if (first) begin
                first = 1'b0;
                tests_run++;
                if (s_en !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL start_latency: rd_en got %b expected 1", s_en);
                end
            end
            if (prev_stall) begin
                tests_run++;
                if (s_en !== 1'b1 || s_addr !== prev_addr) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_hold: got en=%b addr=%0d expected en=1 addr=%0d", s_en, s_addr, prev_addr);
                end
            end
            tests_run++;
            if (inflight.size() > MAX_P || (inflight.size() == MAX_P && s_en !== 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL pending_limit: pending=%0d rd_en=%b expected pending<=%0d and rd_en=0 at limit", inflight.size(), s_en, MAX_P);
            end
            if (abort_at > 0 && returned >= abort_at) begin
                aborted = 1'b1;
                break;
            end
            wait_req = ($urandom_range(0, 99) < stall_pct);
            if (s_en === 1'b1 && !wait_req) begin
                tests_run++;
                if (exp_addr.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL extra_request: got addr %0d expected no request", s_addr);
                end else begin
                    a = exp_addr.pop_front();
                    if (s_addr !== 25'(a)) begin
                        tests_failed++;
                        $display("[TB] FAIL req_addr: got %0d expected %0d", s_addr, a);
                    end
                end
                inflight.push_back('{addr: s_addr[8:0], due: cyc + lat});
            end
            prev_stall = (s_en === 1'b1) && wait_req;
            prev_addr  = s_addr;
            deliver(1'b1);
        end
        rd_valid = 1'b0;
        wait_req = 1'b0;
        if (!fin && !aborted) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL timeout: got no done after %0d cycles, expected done", guard);
        end
        if (fin) begin
`ifdef TEST_SDRAM_READ_CAPTURE_EN
            exp_fa = m_first_addr;
            exp_fd = m_first_data;
`else
            exp_fa = 9'd0;
            exp_fd = 16'd0;
`endif
            tests_run++;
            if (exp_addr.size() != 0) begin
                tests_failed++;
                $display("[TB] FAIL missing_requests: got %0d unrequested expected 0", exp_addr.size());
            end
            tests_run++;
            if (s_pass !== (m_err == 16'd0)) begin
                tests_failed++;
                $display("[TB] FAIL pass_flag: got %b expected %b", s_pass, (m_err == 16'd0));
            end
            tests_run++;
            if (s_fa !== exp_fa || s_fd !== exp_fd) begin
                tests_failed++;
                $display("[TB] FAIL first_err: got %0d/%h expected %0d/%h", s_fa, s_fd, exp_fa, exp_fd);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (a_rd_en !== 1'b0 || a_rd_addr !== 25'd0 || a_done !== 1'b0 || a_pass !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctl: got en=%b addr=%0d done=%b pass=%b expected all 0", a_rd_en, a_rd_addr, a_done, a_pass);
        end
        tests_run++;
        if (a_err !== 16'd0 || a_fa !== 9'd0 || a_fd !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_err: got cnt=%0d fa=%0d fd=%h expected 0", a_err, a_fa, a_fd);
        end
        tests_run++;
        if (b_rd_en !== 1'b0 || b_done !== 1'b0 || b_err !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_small: got en=%b done=%b cnt=%0d expected 0", b_rd_en, b_done, b_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (a_rd_en !== 1'b0 || a_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_hold: got en=%b done=%b expected 0 with start low", a_rd_en, a_done);
        end
    endtask

    task automatic test_clean();
        bit ab;
        $display("[TB] clean run");
        sel = 1'b0;
        corrupt = 1'b0;
        do_reset();
        run_check(2, 0, 400, 0, ab);
        tests_run++;
        if (a_pass !== 1'b1 || a_err !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL clean_result: got pass=%b cnt=%0d expected pass=1 cnt=0", a_pass, a_err);
        end
    endtask

    task automatic test_stalls();
        bit ab;
        $display("[TB] random stalls");
        sel = 1'b0;
        corrupt = 1'b0;
        do_reset();
        run_check(2, 50, 400, 0, ab);
        tests_run++;
        if (a_pass !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_result: got pass=%b expected 1", a_pass);
        end
    endtask

    task automatic test_corruption();
        bit ab;
        $display("[TB] corruption");
        sel = 1'b0;
        corrupt = 1'b1;
        do_reset();
        run_check(2, 0, 400, 0, ab);
        corrupt = 1'b0;
        tests_run++;
        if (a_err !== 16'd2 || a_pass !== 1'b0 || a_done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL corrupt_result: got cnt=%0d pass=%b done=%b expected cnt=2 pass=0 done=1", a_err, a_pass, a_done);
        end
`ifdef TEST_SDRAM_READ_CAPTURE_EN
        tests_run++;
        if (a_fa !== 9'd17 || a_fd !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL corrupt_first: got %0d/%h expected 17/0000", a_fa, a_fd);
        end
`endif
    endtask

    task automatic test_long_latency();
        bit ab;
        $display("[TB] long latency");
        sel = 1'b0;
        corrupt = 1'b0;
        do_reset();
        run_check(20, 0, 400, 0, ab);
        tests_run++;
        if (a_pass !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL latency_result: got pass=%b expected 1", a_pass);
        end
    endtask

    task automatic test_reset_mid();
        bit ab;
        $display("[TB] reset mid-check");
        sel = 1'b0;
        corrupt = 1'b0;
        do_reset();
        run_check(5, 0, 400, 150, ab);
        tests_run++;
        if (!ab) begin
            tests_failed++;
            $display("[TB] FAIL mid_abort: got no abort point expected word 150 reached");
        end
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        tests_run++;
        if (a_rd_en !== 1'b0 || a_rd_addr !== 25'd0 || a_done !== 1'b0 || a_pass !== 1'b0 ||
            a_err !== 16'd0 || a_fa !== 9'd0 || a_fd !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_vals: got en=%b addr=%0d cnt=%0d expected reset values", a_rd_en, a_rd_addr, a_err);
        end
        // Two cycles of reset, then stale words keep arriving in IDLE.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cyc++;
            deliver(1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cyc++;
            tests_run++;
            if (a_err !== 16'd0 || a_rd_en !== 1'b0 || a_done !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stale_ignored: got cnt=%0d en=%b done=%b expected 0", a_err, a_rd_en, a_done);
            end
            deliver(1'b0);
        end
        rd_valid = 1'b0;
        run_check(5, 0, 400, 0, ab);
        tests_run++;
        if (a_pass !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL fresh_result: got pass=%b expected 1", a_pass);
        end
    endtask

    task automatic test_boundary();
        bit ab;
        $display("[TB] boundary N_WORDS=1");
        sel = 1'b1;
        corrupt = 1'b0;
        do_reset();
        run_check(2, 0, 1, 0, ab);
        tests_run++;
        if (b_pass !== 1'b1 || b_err !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL one_result: got pass=%b cnt=%0d expected pass=1 cnt=0", b_pass, b_err);
        end
        @(negedge clk);
        tests_run++;
        if (b_done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL done_hold: got %b expected 1 while start high", b_done);
        end
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (b_done !== 1'b0 || b_pass !== 1'b0 || b_rd_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL back_to_idle: got done=%b pass=%b en=%b expected 0", b_done, b_pass, b_rd_en);
        end
        sel = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        wait_req = 1'b0;
        rd_data  = 16'd0;
        rd_valid = 1'b0;
        sel      = 1'b0;
        corrupt  = 1'b0;
        cyc      = 0;
        returned = 0;
        m_err        = 16'd0;
        m_first_addr = 9'd0;
        m_first_data = 16'd0;
        test_reset();
        test_clean();
        test_stalls();
        test_corruption();
        test_long_latency();
        test_reset_mid();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
